fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32, the data and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-003 Parameter DEPTH, default 2, the number of entries in the instruction buffer; must be a power of 2 and at least 2.
REQ-004 Clock and reset SHALL be fixed as one clock and an asynchronous, active-high reset.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rom_address  output  WIDTH  byte address to instruction ROM; equals pc combinationally.
REQ-008 rom_rdata  input  WIDTH  asynchronous ROM read data for rom_address, valid in the same cycle.
REQ-009 redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-010 redirect_pc  input  WIDTH  new fetch target; bits [1:0] are ignored (forced 0).
REQ-011 inst_valid  output  1  buffer head holds a valid instruction.
REQ-012 inst_ready  input  1  decode accepts the head this cycle.
REQ-013 inst  output  WIDTH  head instruction word.
REQ-014 inst_pc  output  WIDTH  address the head instruction was fetched from.

Function
REQ-015 State: pc register; DEPTH-entry FIFO of {pc, instruction}; read pointer, write pointer and count of log2(DEPTH)+1 bits.
REQ-016 pop = inst_valid && inst_ready.
REQ-017 push = !redirect_valid && (count < DEPTH || pop).
REQ-018 On push, the FIFO SHALL write {pc, rom_rdata} at the write pointer and set pc <= pc + 4.
REQ-019 pc + 4 SHALL wrap modulo 2^WIDTH, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-020 On pop, the read pointer SHALL advance.
REQ-021 On a simultaneous push and pop, count SHALL be unchanged.
REQ-022 Both pointers SHALL wrap at DEPTH.
REQ-023 When redirect_valid = 1, the following SHALL take priority over push and pop:
  - count, the read pointer and the write pointer are cleared;
  - pc <= {redirect_pc[WIDTH-1:2], 2'b00};
  - no entry is written that cycle.
REQ-024 A handshake in the same cycle as a redirect SHALL count as consumed by decode; the rest of the FIFO is discarded.
REQ-025 inst_valid SHALL equal (count != 0).
REQ-026 When count = 0, inst and inst_pc SHALL be 0.
REQ-027 When count != 0, inst and inst_pc SHALL be the head entry.
REQ-028 Latency: an address presented at rom_address in cycle N SHALL appear at the buffer head no earlier than cycle N+1. No path from rom_rdata to inst is combinational.
REQ-029 After a redirect in cycle N, the first instruction from the new target SHALL be fetched in cycle N+1 and presented in cycle N+2.
REQ-030 With count = DEPTH and inst_ready = 0, pc SHALL hold, rom_address SHALL hold, and the FIFO contents SHALL be unchanged (no overwrite).
REQ-031 Full with pop in the same cycle: push SHALL occur, giving sustained throughput of 1 instruction/cycle when inst_ready stays high.
REQ-032 inst and inst_pc SHALL remain stable while inst_valid = 1 and inst_ready = 0.

Reset
REQ-033 Asserting reset SHALL immediately set pc = RESET_PC, count = 0 and both pointers = 0.
REQ-034 While reset is asserted, outputs SHALL be inst_valid = 0, inst = 0, inst_pc = 0 and rom_address = RESET_PC.
REQ-035 Reset asserted mid-stream SHALL discard all buffered entries; no entry is pushed while reset is high.
REQ-036 The first push SHALL occur on the first rising edge after reset deasserts.
REQ-037 FIFO storage need not be reset; only valid state is defined.

Verification
REQ-038 Reset, then run with inst_ready = 1 over a ROM holding word i = i:
  - inst_valid rises 1 cycle after release;
  - inst/inst_pc sequence is 0/0x0, 1/0x4, 2/0x8, ...;
  - 1 instruction per cycle, no gaps.
REQ-039 Backpressure: hold inst_ready = 0 for 5 cycles, then release:
  - count saturates at 2 and rom_address freezes at 0x8;
  - head stays at inst_pc = 0x0 throughout the stall;
  - after release, 0x0, 0x4, 0x8 arrive in order with none lost or duplicated.
REQ-040 Redirect with the FIFO full, redirect_pc = 0x0000_0103:
  - next cycle inst_valid = 0 and rom_address = 0x100;
  - following cycle inst_pc = 0x100.
REQ-041 Redirect and handshake in the same cycle:
  - the accepted instruction is counted once;
  - no stale entry from before the redirect appears afterwards.
REQ-042 Wrap: redirect to 0xFFFF_FFF8 with inst_ready = 1 gives inst_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-043 Asynchronous reset asserted between clock edges with the FIFO full: inst_valid drops to 0 before the next edge, and rom_address = RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives the ROM address from a PC register and buffers
// {pc, instruction} pairs in a small FIFO in front of decode.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int               DEPTH    = 2
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] rom_address,
    input  logic [WIDTH-1:0] rom_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [WIDTH-1:0] inst_mem [DEPTH];

    logic pop;
    logic push;

    assign rom_address = pc_q;
    assign inst_valid  = (cnt_q != '0);
    assign inst        = inst_valid ? inst_mem[rd_ptr_q] : '0;
    assign inst_pc     = inst_valid ? pc_mem[rd_ptr_q]   : '0;

    // A full buffer can still accept a new word when the head leaves this cycle.
    assign pop  = inst_valid && inst_ready;
    assign push = !redirect_valid && ((cnt_q < CNT_W'(DEPTH)) || pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[WIDTH-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pc_q + WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; only entries covered by cnt_q are ever visible.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            pc_mem[wr_ptr_q]   <= pc_q;
            inst_mem[wr_ptr_q] <= rom_rdata;
        end
    end

endmodule
